// File: rtl/key_command_scheduler_pkg.sv
// Shared definitions for the key command scheduler: FSM states, default
// timing constants and key index assignments.
package key_command_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } sched_state_t;

  localparam int unsigned DEF_NKEY         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 500000;    // 10 ms @ 50 MHz
  localparam int unsigned DEF_REPEAT_DELAY = 25000000;  // 500 ms
  localparam int unsigned DEF_REPEAT_RATE  = 5000000;   // 100 ms
  localparam logic [3:0]  DEF_REPEAT_MASK  = 4'b1110;

  localparam int unsigned KEY_HALF = 0;
  localparam int unsigned KEY_DN1  = 1;
  localparam int unsigned KEY_UP1  = 2;
  localparam int unsigned KEY_DN10 = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_command_scheduler_debounce.sv
// Single-key front end: 2-flop synchroniser, debounce counter and a
// registered rising-edge detect on the debounced (active-high) level.
module key_debounce
  import key_command_scheduler_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic key_n,
  output logic key_level,
  output logic key_rise
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic          pressed;
  logic [CW-1:0] cnt;

  assign pressed = ~sync2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      cnt       <= '0;
      key_level <= 1'b0;
      level_d   <= 1'b0;
      key_rise  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      // Any sample agreeing with the current level restarts the stability window.
      if (pressed == key_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        key_level <= pressed;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d  <= key_level;
      key_rise <= key_level & ~level_d;
    end
  end

endmodule

// File: rtl/key_command_scheduler.sv
// Debounces the board keys, arbitrates ownership of the command channel and
// emits single-cycle one-hot command pulses with long-press auto-repeat.
module key_command_scheduler
  import key_command_scheduler_pkg::*;
#(
  parameter int unsigned      NKEY         = DEF_NKEY,
  parameter int unsigned      DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned      REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned      REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [NKEY-1:0]  REPEAT_MASK  = NKEY'(DEF_REPEAT_MASK)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NKEY-1:0] Key_In,
  output logic [NKEY-1:0] Key_Pulse,
  output logic            Key_Busy
);

  localparam int unsigned TMAX = max_u(REPEAT_DELAY, REPEAT_RATE);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned OW   = (NKEY > 1) ? $clog2(NKEY) : 1;

  logic [NKEY-1:0] key_level;
  logic [NKEY-1:0] key_rise;

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .key_n    (Key_In[g]),
      .key_level(key_level[g]),
      .key_rise (key_rise[g])
    );
  end

  sched_state_t    state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NKEY-1:0] pulse_d;
  logic [OW-1:0]   winner;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    timer_d = timer_q;
    pulse_d = '0;
    winner  = '0;
    // Ascending scan: the last hit is the highest-index key.
    for (int unsigned i = 0; i < NKEY; i++) begin
      if (key_rise[i]) winner = OW'(i);
    end
    case (state_q)
      ST_IDLE: begin
        if (|key_rise) begin
          owner_d         = winner;
          pulse_d[winner] = 1'b1;
          timer_d         = '0;
          state_d         = REPEAT_MASK[winner] ? ST_DELAY : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!key_level[owner_q]) state_d = ST_IDLE;
      end
      ST_DELAY: begin
        if (!key_level[owner_q]) begin
          state_d = ST_IDLE;
        end else if (timer_q == TW'(REPEAT_DELAY - 1)) begin
          pulse_d[owner_q] = 1'b1;
          timer_d          = '0;
          state_d          = ST_REPEAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!key_level[owner_q]) begin
          state_d = ST_IDLE;
        end else if (timer_q == TW'(REPEAT_RATE - 1)) begin
          pulse_d[owner_q] = 1'b1;
          timer_d          = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      timer_q   <= '0;
      Key_Pulse <= '0;
      Key_Busy  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      Key_Pulse <= pulse_d;
      Key_Busy  <= (state_d != ST_IDLE);
    end
  end

endmodule
